// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: datapath widths, the hard-wired zero register
// and the MemtoReg select encoding used by control, MEM/WB and writeback.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MEM = 1'b1;

endpackage

// File: rtl/wb_regfile_core.sv
// Architectural integer register storage with synchronous clear, a
// hard-wired zero register and two raw combinational read ports.
module regfile_core #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // x0 is excluded from writes here as well, so the storage never holds a
  // stale value there even if a caller forgets to gate the enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != ADDR_W'(ZERO_REG))) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == ADDR_W'(ZERO_REG)) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == ADDR_W'(ZERO_REG)) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the register
// file, bypasses it to same-cycle ID reads and counts committed writes.
module wb_regfile #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] ALUdata_i,
  input  logic [DATA_W-1:0] ReadData_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] WBdata_o,
  output logic              WBvalid_o,
  output logic [CNT_W-1:0]  WrCount_o
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] wbData;
  logic              wbValid;
  logic [DATA_W-1:0] rawData1;
  logic [DATA_W-1:0] rawData2;
  logic [CNT_W-1:0]  wrCount_q;
  logic [CNT_W-1:0]  wrCount_d;

  assign wbData  = (MemtoReg_i == SEL_MEM) ? ReadData_i : ALUdata_i;
  assign wbValid = RegWrite_i && (RDaddr_i != ADDR_W'(ZERO_REG));

  regfile_core #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_core (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wbValid),
    .waddr_i (RDaddr_i),
    .wdata_i (wbData),
    .raddr1_i(RS1addr_i),
    .raddr2_i(RS2addr_i),
    .rdata1_o(rawData1),
    .rdata2_o(rawData2)
  );

  // A bypass hit can never target x0 because wbValid already excludes it,
  // so the core's zero rule stays authoritative for address 0.
  assign RS1data_o = (wbValid && (RDaddr_i == RS1addr_i)) ? wbData : rawData1;
  assign RS2data_o = (wbValid && (RDaddr_i == RS2addr_i)) ? wbData : rawData2;

  always_comb begin
    wrCount_d = wrCount_q;
    if (wbValid) begin
      wrCount_d = wrCount_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrCount_q <= '0;
    end else begin
      wrCount_q <= wrCount_d;
    end
  end

  assign WBdata_o  = wbData;
  assign WBvalid_o = wbValid;
  assign WrCount_o = wrCount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic compared against an array-based architectural model.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          RegWrite_i;
  logic          MemtoReg_i;
  logic [DW-1:0] ALUdata_i;
  logic [DW-1:0] ReadData_i;
  logic [AW-1:0] RDaddr_i;
  logic [AW-1:0] RS1addr_i;
  logic [AW-1:0] RS2addr_i;
  logic [DW-1:0] RS1data_o;
  logic [DW-1:0] RS2data_o;
  logic [DW-1:0] WBdata_o;
  logic          WBvalid_o;
  logic [CW-1:0] WrCount_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [NR];
  int          modelCnt;

  wb_regfile #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_REGS(NR),
    .CNT_W   (CW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .RegWrite_i(RegWrite_i),
    .MemtoReg_i(MemtoReg_i),
    .ALUdata_i (ALUdata_i),
    .ReadData_i(ReadData_i),
    .RDaddr_i  (RDaddr_i),
    .RS1addr_i (RS1addr_i),
    .RS2addr_i (RS2addr_i),
    .RS1data_o (RS1data_o),
    .RS2data_o (RS2data_o),
    .WBdata_o  (WBdata_o),
    .WBvalid_o (WBvalid_o),
    .WrCount_o (WrCount_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expRead(input int addr, input bit valid,
                                          input int rd, input logic [31:0] wb);
    if (addr == 0) return 32'h0;
    if (valid && rd == addr) return wb;
    return model[addr];
  endfunction

  // Drives one cycle at the falling edge, checks the combinational view,
  // then advances the model across the rising edge and checks the counter.
  task automatic applyStimulus(input bit rst, input bit rw, input bit m2r,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input int rd, input int rs1, input int rs2);
    logic [31:0] wb;
    bit          valid;
    @(negedge clk_i);
    rst_i      = rst;
    RegWrite_i = rw;
    MemtoReg_i = m2r;
    ALUdata_i  = alu;
    ReadData_i = mem;
    RDaddr_i   = AW'(rd);
    RS1addr_i  = AW'(rs1);
    RS2addr_i  = AW'(rs2);
    wb    = m2r ? mem : alu;
    valid = rw && (rd != 0);
    #1;
    checkOutput("WBdata", WBdata_o, wb);
    checkOutput("WBvalid", {31'b0, WBvalid_o}, {31'b0, valid});
    checkOutput("RS1data", RS1data_o, expRead(rs1, valid, rd, wb));
    checkOutput("RS2data", RS2data_o, expRead(rs2, valid, rd, wb));
    @(posedge clk_i);
    #1;
    if (rst) begin
      for (int i = 0; i < NR; i++) model[i] = 32'h0;
      modelCnt = 0;
    end else if (valid) begin
      model[rd] = wb;
      modelCnt  = (modelCnt + 1) % (1 << CW);
    end
    checkOutput("WrCount", 32'(WrCount_o), 32'(modelCnt));
  endtask

  initial begin
    rst_i = 1'b1; RegWrite_i = 1'b0; MemtoReg_i = 1'b0;
    ALUdata_i = '0; ReadData_i = '0; RDaddr_i = '0; RS1addr_i = '0; RS2addr_i = '0;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    modelCnt = 0;

    // Reset state: every address reads zero on both ports
    for (int i = 0; i < NR; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, i, i, NR - 1 - i);
      checkOutput("reset_read1", RS1data_o, 32'h0);
      checkOutput("reset_read2", RS2data_o, 32'h0);
    end
    checkOutput("reset_count", 32'(WrCount_o), 32'h0);

    // ALU write then read back
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_00A5, 32'h0, 3, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 3, 0);
    checkOutput("x3_readback", RS1data_o, 32'h0000_00A5);
    checkOutput("count_one", 32'(WrCount_o), 32'h1);

    // Memory write with both ports bypassing
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 7, 7, 7);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 7, 3);
    checkOutput("x7_readback", RS1data_o, 32'hDEAD_BEEF);

    // Write aimed at x0 is ignored
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 7);
    checkOutput("x0_zero", RS1data_o, 32'h0);
    checkOutput("count_x0", 32'(WrCount_o), 32'h2);

    // Reset drops both the committed x5 and the concurrent x6 write
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 5, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h66, 32'h0, 6, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 5, 6);
    checkOutput("x5_cleared", RS1data_o, 32'h0);
    checkOutput("x6_cleared", RS2data_o, 32'h0);
    checkOutput("count_cleared", 32'(WrCount_o), 32'h0);

    // Counter wrap at 2**CW - 1
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, $urandom, 32'h0, 1 + (i % 31), 0, 0);
    end
    checkOutput("count_max", 32'(WrCount_o), 32'd15);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, $urandom, 9, 9, 0);
    checkOutput("count_wrap", 32'(WrCount_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, $urandom, $urandom, 4 + i, 9, 4 + i);
    end
    checkOutput("count_idle", 32'(WrCount_o), 32'd0);

    // Randomized traffic with biased bypass hits and occasional reset
    for (int n = 0; n < 400; n++) begin
      int rd;
      int rs1;
      int rs2;
      rd  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, NR - 1);
      rs1 = ($urandom_range(0, 3) == 0) ? rd : $urandom_range(0, NR - 1);
      rs2 = ($urandom_range(0, 3) == 0) ? rd : $urandom_range(0, NR - 1);
      applyStimulus($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
                    1'($urandom), $urandom, $urandom, rd, rs1, rs2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register. It selects the writeback value (memory read data or ALU result) and commits it to the 32-entry integer register file. It provides two combinational read ports to the ID stage with same-cycle write-to-read bypass. It also exports the writeback value for the forwarding unit and a committed-write counter for performance and debug.

Parameters:
DATA_W, 32, register and datapath width
ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers (2**ADDR_W)
CNT_W, 32, width of committed-write counter

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, synchronous, active-high
RegWrite_i  in  1  write enable from MEM/WB
MemtoReg_i  in  1  1 = write ReadData_i, 0 = write ALUdata_i
ALUdata_i  in  DATA_W  ALU result from MEM/WB
ReadData_i  in  DATA_W  data-memory read value from MEM/WB
RDaddr_i  in  ADDR_W  destination register from MEM/WB
RS1addr_i  in  ADDR_W  ID-stage source 1 address
RS2addr_i  in  ADDR_W  ID-stage source 2 address
RS1data_o  out  DATA_W  source 1 read data
RS2data_o  out  DATA_W  source 2 read data
WBdata_o  out  DATA_W  selected writeback value, to forwarding mux
WBvalid_o  out  1  RegWrite_i and RDaddr_i != 0, to forwarding unit
WrCount_o  out  CNT_W  number of committed register writes since reset

Behaviour:
- WBdata_o = MemtoReg_i ? ReadData_i : ALUdata_i. Combinational; valid in the same cycle as the inputs.
- WBvalid_o = RegWrite_i and (RDaddr_i != 0). Combinational.
- Commit: on rising clk_i with rst_i = 0 and WBvalid_o = 1, regs[RDaddr_i] <= WBdata_o. Write latency is 1 edge.
- x0: never written, and always reads 0, even if RegWrite_i targets x0.
- Read ports are combinational: RSndata_o = 0 if RSnaddr_i == 0.
- Bypass: else if WBvalid_o and RDaddr_i == RSnaddr_i, RSndata_o = WBdata_o. This gives write-before-read in the same cycle.
- Otherwise RSndata_o = regs[RSnaddr_i].
- Both ports may hit the same address or the bypass simultaneously; each resolves independently.
- WrCount_o increments by 1 on each edge where WBvalid_o = 1. Writes to x0 are not counted. The counter wraps modulo 2**CNT_W with no saturation.
- Reset (rst_i = 1 at rising edge):
  - All regs[1..NUM_REGS-1] cleared to 0 and WrCount_o cleared to 0.
  - Any write presented in the same cycle is dropped and not counted.
  - Reset mid-stream discards in-flight writeback; the first write after rst_i deasserts commits normally.
- During reset, read ports still behave combinationally (registers read 0 after the first reset edge). Bypass stays active because it depends only on inputs. This is intended: the pipeline register ahead is also flushed to RegWrite = 0.
- No X propagation: RegWrite_i = 0 suppresses all writes regardless of other inputs.

Decomposition:
- Shared package cpu_pkg holds DATA_W, ADDR_W, ZERO_REG (= 0) and the MemtoReg select encoding (SEL_ALU = 0, SEL_MEM = 1), reused by the control unit and the MEM/WB register.
- One sub-module, regfile_core, holds the storage array, reset clear, x0 rule and the two raw read ports.
- The top level holds the writeback mux, the bypass compare, WBvalid_o and the counter.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every read 0, WrCount_o = 0.
- RegWrite = 1, MemtoReg = 0, ALUdata = 0x0000_00A5, RD = 3; next cycle RS1 = 3 -> RS1data = 0x0000_00A5, WrCount_o = 1.
- RegWrite = 1, MemtoReg = 1, ReadData = 0xDEAD_BEEF, ALUdata = 0x1234_5678, RD = 7, with RS1 = RS2 = 7 in the same cycle -> both ports = 0xDEAD_BEEF (bypass), WBdata_o = 0xDEAD_BEEF; after the edge regs[7] = 0xDEAD_BEEF.
- RegWrite = 1, RD = 0, ALUdata = 0xFFFF_FFFF, RS1 = 0 -> RS1data = 0, WBvalid_o = 0, WrCount_o unchanged; x0 still reads 0 next cycle.
- Write x5 = 0x55, then assert rst_i for one edge together with a write x6 = 0x66 -> x5 and x6 both read 0, WrCount_o = 0.
- Force WrCount_o to 2**CNT_W - 1 (use CNT_W = 4 and 15 writes), then one more valid write -> WrCount_o = 0; RegWrite = 0 cycles leave the counter unchanged.
